// File: rtl/apb_prio_intc.sv
// APB-programmable priority interrupt controller: per-line priority, enable mask and
// pending latch, presenting one winning line at a time with optional preemption.
module apb_prio_intc #(
  parameter int NUM_INTR = 16,
  parameter int PRIO_W   = 4,
  parameter bit PREEMPT  = 1'b0
) (
  input  logic                pclk_i,
  input  logic                prst_i,
  input  logic                psel_i,
  input  logic                penable_i,
  input  logic                pwrite_i,
  input  logic [4:0]          paddr_i,
  input  logic [31:0]         pwdata_i,
  output logic [31:0]         prdata_o,
  output logic                pready_o,
  output logic                pslverr_o,
  input  logic [NUM_INTR-1:0] intr_active_i,
  output logic [4:0]          intr_to_service_o,
  output logic                intr_valid_o,
  input  logic                intr_serviced_i
);
  typedef enum logic [1:0] {IDLE, ARB, WAIT} state_t;
  state_t state_q, state_d;

  logic [PRIO_W-1:0]   prio [NUM_INTR];
  logic [NUM_INTR-1:0] enable, pending, eligible, cur_onehot, w1c_mask, svc_mask;
  logic                commit, addr_err, wr_ok;
  logic [31:0]         rd_val;
  logic [4:0]          win_idx, idx_d;
  logic [PRIO_W-1:0]   win_prio, cur_prio;
  logic                any_elig, others_elig, cur_elig, higher_elig, valid_d;

  assign commit   = psel_i & penable_i & ~pready_o;
  assign addr_err = 32'(paddr_i) > 32'(NUM_INTR + 1);
  assign wr_ok    = commit & pwrite_i & ~addr_err;
  assign w1c_mask = (wr_ok && paddr_i == 5'(NUM_INTR + 1)) ? pwdata_i[NUM_INTR-1:0] : '0;

  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < NUM_INTR; i++)
      if (paddr_i == 5'(i)) rd_val = 32'(prio[i]);
    if (paddr_i == 5'(NUM_INTR))     rd_val = 32'(enable);
    if (paddr_i == 5'(NUM_INTR + 1)) rd_val = 32'(pending);
  end

  // New requests are OR-ed in last so a same-cycle set beats W1C or service clear.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      for (int unsigned i = 0; i < NUM_INTR; i++) prio[i] <= '0;
      enable    <= '0;
      pending   <= '0;
      prdata_o  <= '0;
      pready_o  <= 1'b0;
      pslverr_o <= 1'b0;
    end else begin
      pending   <= (pending & ~w1c_mask & ~svc_mask) | intr_active_i;
      pready_o  <= commit;
      pslverr_o <= commit & addr_err;
      if (commit && (addr_err || !pwrite_i)) prdata_o <= addr_err ? '0 : rd_val;
      if (wr_ok) begin
        for (int unsigned i = 0; i < NUM_INTR; i++)
          if (paddr_i == 5'(i)) prio[i] <= pwdata_i[PRIO_W-1:0];
        if (paddr_i == 5'(NUM_INTR)) enable <= pwdata_i[NUM_INTR-1:0];
      end
    end
  end

  // Strict '>' while scanning upward keeps ties on the lowest index.
  always_comb begin
    win_idx  = '0;
    win_prio = '0;
    cur_prio = '0;
    cur_elig = 1'b0;
    for (int unsigned i = 0; i < NUM_INTR; i++) begin
      eligible[i]   = pending[i] & enable[i] & (prio[i] != '0);
      cur_onehot[i] = (intr_to_service_o == 5'(i));
      if (eligible[i] && prio[i] > win_prio) begin
        win_prio = prio[i];
        win_idx  = 5'(i);
      end
      if (cur_onehot[i]) begin
        cur_prio = prio[i];
        cur_elig = eligible[i];
      end
    end
  end

  always_comb begin
    higher_elig = 1'b0;
    for (int unsigned i = 0; i < NUM_INTR; i++)
      if (eligible[i] && prio[i] > cur_prio) higher_elig = 1'b1;
  end

  assign any_elig    = |eligible;
  assign others_elig = |(eligible & ~cur_onehot);

  always_ff @(posedge pclk_i) begin
    if (prst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (any_elig) state_d = ARB;
      ARB:  state_d = any_elig ? WAIT : IDLE;
      WAIT: begin
        if (intr_serviced_i) state_d = others_elig ? ARB : IDLE;
        else if (!cur_elig || (PREEMPT && higher_elig)) state_d = ARB;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d  = intr_valid_o;
    idx_d    = intr_to_service_o;
    svc_mask = '0;
    unique case (state_q)
      ARB: begin
        valid_d = any_elig;
        idx_d   = any_elig ? win_idx : '0;
      end
      WAIT: begin
        if (intr_serviced_i) begin
          svc_mask = cur_onehot;
          valid_d  = 1'b0;
          idx_d    = '0;
        end else if (!cur_elig || (PREEMPT && higher_elig)) begin
          valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      intr_valid_o      <= 1'b0;
      intr_to_service_o <= '0;
    end else begin
      intr_valid_o      <= valid_d;
      intr_to_service_o <= idx_d;
    end
  end
endmodule

// File: tb/tb_apb_prio_intc.sv
// Bench for apb_prio_intc: two instances (no preemption / preemption) share all inputs,
// checked against a register/pending model and an arbitration rule computed from arrays.
module tb_apb_prio_intc;
  localparam int N  = 16;
  localparam int PW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, psel = 1'b0, penable = 1'b0, pwrite = 1'b0, serviced = 1'b0;
  logic [4:0]    paddr = '0;
  logic [31:0]   pwdata = '0;
  logic [N-1:0]  active = '0;
  logic [31:0]   prdata, prdata_p;
  logic          pready, pready_p, pslverr, pslverr_p, valid, valid_p;
  logic [4:0]    idx, idx_p;

  int errors = 0;
  int checks = 0;

  logic [PW-1:0] m_prio [N];
  logic [N-1:0]  m_en, m_pend;

  apb_prio_intc #(.NUM_INTR(N), .PRIO_W(PW), .PREEMPT(1'b0)) dut (
    .pclk_i(clk), .prst_i(rst), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata), .pready_o(pready),
    .pslverr_o(pslverr), .intr_active_i(active), .intr_to_service_o(idx),
    .intr_valid_o(valid), .intr_serviced_i(serviced));

  apb_prio_intc #(.NUM_INTR(N), .PRIO_W(PW), .PREEMPT(1'b1)) dut_p (
    .pclk_i(clk), .prst_i(rst), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata_p), .pready_o(pready_p),
    .pslverr_o(pslverr_p), .intr_active_i(active), .intr_to_service_o(idx_p),
    .intr_valid_o(valid_p), .intr_serviced_i(serviced));

  function automatic logic [31:0] exp_read(input int a);
    if (a < N)      return 32'(m_prio[a]);
    if (a == N)     return 32'(m_en);
    if (a == N + 1) return 32'(m_pend);
    return 32'd0;
  endfunction

  function automatic int model_winner();
    int best = -1;
    int bp = 0;
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_en[i] && int'(m_prio[i]) > bp) begin
        bp = int'(m_prio[i]);
        best = i;
      end
    return best;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_prio[i] = '0;
    m_en = '0;
    m_pend = '0;
  endfunction

  task automatic apb(input logic wr, input logic [4:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (pready) break;
    end
    checks++;
    if (pready !== 1'b1) begin
      errors++;
      $display("FAIL apb_ready_timeout addr=%0d got pready=%b exp 1", a, pready);
    end
    rd = prdata;
    err = pslverr;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic reg_write(input int a, input logic [31:0] d);
    logic [31:0] rd;
    logic err;
    apb(1'b1, 5'(a), d, rd, err);
    if (a < N)           m_prio[a] = d[PW-1:0];
    else if (a == N)     m_en = d[N-1:0];
    else if (a == N + 1) m_pend = m_pend & ~d[N-1:0];
  endtask

  task automatic clear_regs();
    for (int i = 0; i < N; i++) reg_write(i, 32'd0);
    reg_write(N, 32'd0);
    reg_write(N + 1, 32'hFFFF_FFFF);
    m_pend = '0;
  endtask

  task automatic pulse(input logic [N-1:0] lines);
    @(negedge clk);
    active = lines;
    @(negedge clk);
    active = '0;
  endtask

  task automatic service();
    serviced = 1'b1;
    @(negedge clk);
    serviced = 1'b0;
  endtask

  task automatic wait_valid(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic err;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({prdata, pready, pslverr, idx, valid} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", {prdata, pready, pslverr, idx, valid});
    end
    checks++;
    if ({prdata_p, pready_p, pslverr_p, idx_p, valid_p} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_p got=%h exp=0", {prdata_p, pready_p, pslverr_p, idx_p, valid_p});
    end
    rst = 1'b0;
    model_reset();
    for (int a = 0; a < N + 2; a += 5) begin
      apb(1'b0, 5'(a), 32'd0, rd, err);
      checks++;
      if (rd !== 32'd0) begin
        errors++;
        $display("FAIL reset_read addr=%0d got=%h exp=0", a, rd);
      end
    end
  endtask

  task automatic test_regs();
    logic [31:0] rd;
    logic err;
    int a;
    reg_write(3, 32'd5);
    reg_write(N, 32'h0000_0008);
    apb(1'b0, 5'd3, 32'd0, rd, err);
    checks++;
    if (rd !== 32'd5 || err !== 1'b0) begin
      errors++;
      $display("FAIL prio3_read got=%h/%b exp=5/0", rd, err);
    end
    @(negedge clk);
    checks++;
    if (pready !== 1'b0) begin
      errors++;
      $display("FAIL pready_one_cycle got=%b exp=0", pready);
    end
    reg_write(0, 32'd3);
    checks++;
    if (prdata !== 32'd5) begin
      errors++;
      $display("FAIL prdata_hold got=%h exp=5", prdata);
    end
    for (int k = 0; k < 24; k++) begin
      a = $urandom_range(0, N + 1);
      reg_write(a, $urandom);
      a = $urandom_range(0, N + 1);
      apb(1'b0, 5'(a), 32'd0, rd, err);
      checks++;
      if (rd !== exp_read(a) || err !== 1'b0) begin
        errors++;
        $display("FAIL rand_read addr=%0d got=%h/%b exp=%h/0", a, rd, err, exp_read(a));
      end
    end
  endtask

  task automatic test_err();
    logic [31:0] rd;
    logic err;
    reg_write(3, 32'd5);
    apb(1'b0, 5'd3, 32'd0, rd, err);
    apb(1'b0, 5'd31, 32'd0, rd, err);
    checks++;
    if (rd !== 32'd0 || err !== 1'b1 || prdata !== 32'd0) begin
      errors++;
      $display("FAIL err_read31 got=%h/%b exp=0/1", rd, err);
    end
    apb(1'b0, 5'(N + 1), 32'd0, rd, err);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL edge_addr_err got=%b exp=0", err);
    end
    apb(1'b1, 5'(N + 2), 32'hFFFF_FFFF, rd, err);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_write got=%b exp=1", err);
    end
    for (int a = 0; a < N + 2; a++) begin
      apb(1'b0, 5'(a), 32'd0, rd, err);
      checks++;
      if (rd !== exp_read(a)) begin
        errors++;
        $display("FAIL err_no_change addr=%0d got=%h exp=%h", a, rd, exp_read(a));
      end
    end
  endtask

  task automatic test_latency();
    logic [31:0] rd;
    logic err;
    clear_regs();
    reg_write(5, 32'd3);
    reg_write(N, 32'h0000_0020);
    pulse(16'h0020);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL lat_n got=%b exp=0", valid); end
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL lat_n1 got=%b exp=0", valid); end
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || idx !== 5'd5) begin
      errors++;
      $display("FAIL lat_n2 got=%b/%0d exp=1/5", valid, idx);
    end
    service();
    checks++;
    if (valid !== 1'b0 || idx !== 5'd0) begin
      errors++;
      $display("FAIL lat_service got=%b/%0d exp=0/0", valid, idx);
    end
    apb(1'b0, 5'(N + 1), 32'd0, rd, err);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL lat_pending got=%h exp=0", rd); end
  endtask

  task automatic test_tie();
    logic ok;
    clear_regs();
    reg_write(2, 32'd7);
    reg_write(9, 32'd7);
    reg_write(N, 32'h0000_0204);
    pulse(16'h0204);
    wait_valid(ok);
    checks++;
    if (ok !== 1'b1 || idx !== 5'd2) begin
      errors++;
      $display("FAIL tie_first got=%b/%0d exp=1/2", ok, idx);
    end
    service();
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL tie_drop got=%b exp=0", valid); end
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || idx !== 5'd9) begin
      errors++;
      $display("FAIL tie_second got=%b/%0d exp=1/9", valid, idx);
    end
    service();
    repeat (3) @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL tie_idle got=%b exp=0", valid); end
  endtask

  task automatic test_masked();
    logic [31:0] rd;
    logic err;
    logic seen;
    clear_regs();
    reg_write(N, 32'h0000_0010);
    pulse(16'h0010);
    seen = 1'b0;
    repeat (5) begin @(negedge clk); seen |= valid; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL masked_prio0 got=%b exp=0", seen); end
    service();
    apb(1'b0, 5'(N + 1), 32'd0, rd, err);
    checks++;
    if (rd !== 32'h10) begin errors++; $display("FAIL masked_pending got=%h exp=10", rd); end
    reg_write(N, 32'd0);
    reg_write(4, 32'd3);
    seen = 1'b0;
    repeat (5) begin @(negedge clk); seen |= valid; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL masked_en0 got=%b exp=0", seen); end
    reg_write(N + 1, 32'h10);
    apb(1'b0, 5'(N + 1), 32'd0, rd, err);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL w1c_pending got=%h exp=0", rd); end
  endtask

  task automatic test_preempt();
    logic ok;
    clear_regs();
    reg_write(1, 32'd2);
    reg_write(6, 32'd9);
    reg_write(N, 32'h0000_0042);
    pulse(16'h0002);
    wait_valid(ok);
    checks++;
    if (ok !== 1'b1 || idx !== 5'd1 || valid_p !== 1'b1 || idx_p !== 5'd1) begin
      errors++;
      $display("FAIL pre_first got=%b/%0d %b/%0d exp=1/1 1/1", ok, idx, valid_p, idx_p);
    end
    pulse(16'h0040);
    @(negedge clk);
    checks++;
    if (valid_p !== 1'b0 || valid !== 1'b1 || idx !== 5'd1) begin
      errors++;
      $display("FAIL pre_drop got=%b %b/%0d exp=0 1/1", valid_p, valid, idx);
    end
    @(negedge clk);
    checks++;
    if (valid_p !== 1'b1 || idx_p !== 5'd6 || valid !== 1'b1 || idx !== 5'd1) begin
      errors++;
      $display("FAIL pre_switch got=%b/%0d %b/%0d exp=1/6 1/1", valid_p, idx_p, valid, idx);
    end
    service();
    @(negedge clk);
    checks++;
    if (valid_p !== 1'b1 || idx_p !== 5'd1 || valid !== 1'b1 || idx !== 5'd6) begin
      errors++;
      $display("FAIL pre_after got=%b/%0d %b/%0d exp=1/1 1/6", valid_p, idx_p, valid, idx);
    end
    service();
    repeat (3) @(negedge clk);
    checks++;
    if (valid !== 1'b0 || valid_p !== 1'b0) begin
      errors++;
      $display("FAIL pre_idle got=%b %b exp=0 0", valid, valid_p);
    end
  endtask

  task automatic test_withdraw();
    logic ok;
    clear_regs();
    reg_write(8, 32'd4);
    reg_write(N, 32'h0000_0100);
    pulse(16'h0100);
    wait_valid(ok);
    reg_write(N + 1, 32'h100);
    @(negedge clk);
    checks++;
    if (ok !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL wd_w1c got=%b/%b exp=1/0", ok, valid);
    end
    pulse(16'h0100);
    wait_valid(ok);
    reg_write(N, 32'd0);
    @(negedge clk);
    checks++;
    if (ok !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL wd_enable got=%b/%b exp=1/0", ok, valid);
    end
    reg_write(N, 32'h0000_0100);
    wait_valid(ok);
    reg_write(8, 32'd0);
    @(negedge clk);
    checks++;
    if (ok !== 1'b1 || valid !== 1'b0 || valid_p !== 1'b0) begin
      errors++;
      $display("FAIL wd_prio got=%b/%b/%b exp=1/0/0", ok, valid, valid_p);
    end
    reg_write(N + 1, 32'hFFFF_FFFF);
  endtask

  task automatic test_random_arb();
    logic [31:0] rd;
    logic err;
    logic ok;
    int w;
    for (int r = 0; r < 6; r++) begin
      clear_regs();
      for (int i = 0; i < N; i++) reg_write(i, 32'($urandom_range(0, 15)));
      reg_write(N, $urandom);
      pulse(N'($urandom) | N'(1));
      m_pend = m_pend | active;
      m_pend = '0;
      apb(1'b0, 5'(N + 1), 32'd0, rd, err);
      m_pend = rd[N-1:0];
      w = model_winner();
      while (w >= 0) begin
        wait_valid(ok);
        checks++;
        if (ok !== 1'b1 || idx !== 5'(w) || valid_p !== 1'b1 || idx_p !== 5'(w)) begin
          errors++;
          $display("FAIL rand_winner round=%0d got=%b/%0d/%0d exp=1/%0d", r, ok, idx, idx_p, w);
        end
        service();
        m_pend[w] = 1'b0;
        w = model_winner();
      end
      repeat (3) @(negedge clk);
      apb(1'b0, 5'(N + 1), 32'd0, rd, err);
      checks++;
      if (valid !== 1'b0 || rd !== 32'(m_pend)) begin
        errors++;
        $display("FAIL rand_leftover round=%0d got=%b/%h exp=0/%h", r, valid, rd, 32'(m_pend));
      end
    end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] rd;
    logic err;
    logic ok;
    clear_regs();
    reg_write(7, 32'd6);
    reg_write(N, 32'h0000_0080);
    pulse(16'h0080);
    wait_valid(ok);
    apb(1'b0, 5'd7, 32'd0, rd, err);
    checks++;
    if (ok !== 1'b1 || rd !== 32'd6 || valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_setup got=%b/%h/%b exp=1/6/1", ok, rd, valid);
    end
    psel = 1'b1; penable = 1'b1; paddr = 5'd7; rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({prdata, pready, pslverr, idx, valid, prdata_p, pready_p, pslverr_p, idx_p, valid_p} !== '0) begin
      errors++;
      $display("FAIL rst_inflight got=%h/%b/%b/%0d/%b exp=0", prdata, pready, pslverr, idx, valid);
    end
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    model_reset();
    apb(1'b0, 5'(N + 1), 32'd0, rd, err);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL rst_pending got=%h exp=0", rd); end
    apb(1'b0, 5'd7, 32'd0, rd, err);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL rst_prio got=%h exp=0", rd); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_regs();
    test_err();
    test_latency();
    test_tie();
    test_masked();
    test_preempt();
    test_withdraw();
    test_random_arb();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
